// File: rtl/compression_decompression_dict_if.sv
// Command/response bundle of the run-time dictionary codec.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high; the master holds command/data_in/compressed_in
// stable while cmd_valid is high and not yet accepted. The result outputs
// are meaningful on the single cycle resp_valid is high and hold afterwards.
interface compression_decompression_dict_if #(
  parameter int DATA_W = 80,
  parameter int IDX_W  = 8,
  parameter int DEPTH  = 16
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        command;
  logic [DATA_W-1:0] data_in;
  logic [IDX_W-1:0]  compressed_in;
  logic [IDX_W-1:0]  compressed_out;
  logic [DATA_W-1:0] decompressed_out;
  logic [1:0]        response;
  logic              resp_valid;
  logic              resp_new;
  logic [OCC_W-1:0]  occupancy;

  modport master (
    output cmd_valid, command, data_in, compressed_in,
    input  cmd_ready, compressed_out, decompressed_out, response,
           resp_valid, resp_new, occupancy
  );

  modport slave (
    input  cmd_valid, command, data_in, compressed_in,
    output cmd_ready, compressed_out, decompressed_out, response,
           resp_valid, resp_new, occupancy
  );
endinterface

// File: rtl/compression_decompression_dict.sv
// Run-time built dictionary codec: COMPRESS maps a DATA_W-bit value to its
// dictionary index (inserting it when absent), DECOMPRESS maps an index back
// to its value, CLEAR empties the dictionary. Lookup is a sequential scan.
module compression_decompression_dict #(
  parameter int DATA_W = 80,
  parameter int IDX_W  = 8,
  parameter int DEPTH  = 16
) (
  input  logic       clk,
  input  logic       reset,
  compression_decompression_dict_if.slave bus,
  output logic [1:0] dbg_state
);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] CMD_NOP    = 2'b00;
  localparam logic [1:0] CMD_COMP   = 2'b01;
  localparam logic [1:0] CMD_DECOMP = 2'b10;
  localparam logic [1:0] CMD_CLEAR  = 2'b11;

  localparam logic [1:0] RSP_NONE   = 2'b00;
  localparam logic [1:0] RSP_COMP   = 2'b01;
  localparam logic [1:0] RSP_DECOMP = 2'b10;
  localparam logic [1:0] RSP_ERROR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEARCH  = 2'd1,
    DECODE  = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [OCC_W-1:0]  count_q;
  logic [OCC_W-1:0]  ptr_q;
  logic [1:0]        cmd_q;
  logic [DATA_W-1:0] data_q;
  logic [IDX_W-1:0]  idx_q;
  logic              hit_q;
  logic              idx_ok_q;
  logic [DATA_W-1:0] read_q;

  logic accept;
  logic search_done;
  logic search_hit;
  logic idx_in_range;
  logic has_room;

  assign bus.cmd_ready = (state_q == IDLE);
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign bus.occupancy = count_q;
  assign dbg_state     = state_q;
  assign idx_in_range  = (32'(idx_q) < 32'(count_q));
  assign has_room      = (32'(count_q) < DEPTH);

  // State register; reset aborts any search or decode in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and scan termination (miss at ptr==count, hit on equality).
  always_comb begin
    state_d     = state_q;
    search_done = 1'b0;
    search_hit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (bus.command)
            CMD_COMP:   state_d = SEARCH;
            CMD_DECOMP: state_d = DECODE;
            CMD_CLEAR:  state_d = DECODE;
            default:    state_d = IDLE;
          endcase
        end
      end
      SEARCH: begin
        if (ptr_q == count_q) begin
          search_done = 1'b1;
          state_d     = RESPOND;
        end else if (mem[ptr_q[AW-1:0]] == data_q) begin
          search_done = 1'b1;
          search_hit  = 1'b1;
          state_d     = RESPOND;
        end
      end
      DECODE:  state_d = RESPOND;
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latch, scan pointer and decode read; inputs are not looked at after acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q    <= CMD_NOP;
      data_q   <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
      hit_q    <= 1'b0;
      idx_ok_q <= 1'b0;
      read_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            cmd_q  <= bus.command;
            data_q <= bus.data_in;
            idx_q  <= bus.compressed_in;
            ptr_q  <= '0;
          end
        end
        SEARCH: begin
          if (search_done) hit_q <= search_hit;
          else             ptr_q <= ptr_q + 1'b1;
        end
        DECODE: begin
          idx_ok_q <= idx_in_range;
          read_q   <= idx_in_range ? mem[idx_q[AW-1:0]] : '0;
        end
        default: ;
      endcase
    end
  end

  // Entry storage; only slots below count are ever read, so no reset is needed.
  always_ff @(posedge clk) begin
    if (state_q == RESPOND && cmd_q == CMD_COMP && !hit_q && has_room)
      mem[count_q[AW-1:0]] <= data_q;
  end

  // Result registers and occupancy; all change on the edge that raises resp_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q              <= '0;
      bus.resp_valid       <= 1'b0;
      bus.response         <= RSP_NONE;
      bus.resp_new         <= 1'b0;
      bus.compressed_out   <= '0;
      bus.decompressed_out <= '0;
    end else begin
      bus.resp_valid <= 1'b0;
      if (state_q == RESPOND) begin
        bus.resp_valid       <= 1'b1;
        bus.resp_new         <= 1'b0;
        bus.compressed_out   <= '0;
        bus.decompressed_out <= '0;
        case (cmd_q)
          CMD_COMP: begin
            if (hit_q) begin
              bus.compressed_out <= IDX_W'(ptr_q);
              bus.response       <= RSP_COMP;
            end else if (has_room) begin
              bus.compressed_out <= IDX_W'(count_q);
              bus.response       <= RSP_COMP;
              bus.resp_new       <= 1'b1;
              count_q            <= count_q + 1'b1;
            end else begin
              bus.response <= RSP_ERROR;
            end
          end
          CMD_DECOMP: begin
            if (idx_ok_q) begin
              bus.decompressed_out <= read_q;
              bus.response         <= RSP_DECOMP;
            end else begin
              bus.response <= RSP_ERROR;
            end
          end
          default: begin
            count_q      <= '0;
            bus.response <= RSP_NONE;
          end
        endcase
      end
    end
  end
endmodule
